// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer: op codes,
// FSM state encoding and default latencies.
package e_mdu_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] mdNone  = 4'd0;
    localparam logic [3:0] mdMult  = 4'd1;
    localparam logic [3:0] mdMultu = 4'd2;
    localparam logic [3:0] mdDiv   = 4'd3;
    localparam logic [3:0] mdDivu  = 4'd4;
    localparam logic [3:0] mdMfhi  = 4'd5;
    localparam logic [3:0] mdMflo  = 4'd6;
    localparam logic [3:0] mdMthi  = 4'd7;
    localparam logic [3:0] mdMtlo  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_div(input logic [3:0] op);
        return (op == mdDiv) || (op == mdDivu);
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == mdMult) || (op == mdMultu) || is_div(op);
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// Operand/command/status bundle between the E-stage control and the MDU.
// master = control side driving operands; slave = the MDU sequencer.
interface e_mdu_ctrl_if;

    logic [31:0] MDU_a;
    logic [31:0] MDU_b;
    logic [3:0]  CU_MDU_op;
    logic        CU_MDU_start;
    logic        req;
    logic [31:0] E_MDU_out;
    logic        E_MDU_busy;
    logic        E_MDU_stall;

    modport master (
        output MDU_a, MDU_b, CU_MDU_op, CU_MDU_start, req,
        input  E_MDU_out, E_MDU_busy, E_MDU_stall
    );

    modport slave (
        input  MDU_a, MDU_b, CU_MDU_op, CU_MDU_start, req,
        output E_MDU_out, E_MDU_busy, E_MDU_stall
    );

endinterface

// File: rtl/e_mdu_core.sv
// Combinational multiply/divide arithmetic: {hi, lo} result for the four
// arithmetic ops plus a divide-by-zero flag.
module e_mdu_core
    import e_mdu_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [63:0] res,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb_safe;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] bu_safe;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               div_ovf;

    assign sa       = $signed(a);
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // A divisor of 1 keeps the dividers defined for /0 and turns the
    // 0x80000000 / -1 overflow case into quotient 0x80000000, remainder 0.
    assign sb_safe = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
    assign bu_safe = div_zero ? 32'd1 : b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign q_s    = sa / sb_safe;
    assign r_s    = sa % sb_safe;
    assign q_u    = a / bu_safe;
    assign r_u    = a % bu_safe;

    always_comb begin
        res = '0;
        case (op)
            mdMult:  res = prod_s;
            mdMultu: res = prod_u;
            mdDiv:   res = {r_s, q_s};
            mdDivu:  res = {r_u, q_u};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO with fixed-latency busy.
// Optional MDU_DIVZERO_HOLD_EN: divide by zero leaves HI/LO unchanged.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    e_mdu_ctrl_if.slave  mdu
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        sh_hi;
    logic [31:0]        sh_lo;
    logic [63:0]        core_res;
    logic               core_dz;
    logic               op_go;
    logic               accept_md;
    logic               write_hi;
    logic               write_lo;
    logic               complete;
`ifdef MDU_DIVZERO_HOLD_EN
    logic               dz_hold_q;
`endif

    e_mdu_core u_core (
        .a        (mdu.MDU_a),
        .b        (mdu.MDU_b),
        .op       (mdu.CU_MDU_op),
        .res      (core_res),
        .div_zero (core_dz)
    );

    assign op_go = mdu.CU_MDU_start & ~mdu.req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept_md = 1'b0;
        write_hi  = 1'b0;
        write_lo  = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_go) begin
                    if (is_muldiv(mdu.CU_MDU_op)) begin
                        accept_md = 1'b1;
                        state_d   = RUN;
                    end
                    write_hi = (mdu.CU_MDU_op == mdMthi);
                    write_lo = (mdu.CU_MDU_op == mdMtlo);
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
`ifdef MDU_DIVZERO_HOLD_EN
            dz_hold_q <= 1'b0;
`endif
        end else begin
            if (accept_md) begin
                cnt_q <= is_div(mdu.CU_MDU_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`ifdef MDU_DIVZERO_HOLD_EN
                dz_hold_q      <= core_dz & is_div(mdu.CU_MDU_op);
                {sh_hi, sh_lo} <= core_res;
`else
                // Divide by zero yields HI = dividend, LO = all ones.
                if (core_dz && is_div(mdu.CU_MDU_op)) begin
                    sh_hi <= mdu.MDU_a;
                    sh_lo <= 32'hFFFF_FFFF;
                end else begin
                    {sh_hi, sh_lo} <= core_res;
                end
`endif
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

`ifdef MDU_DIVZERO_HOLD_EN
            if (complete && !dz_hold_q) begin
`else
            if (complete) begin
`endif
                hi_q <= sh_hi;
                lo_q <= sh_lo;
            end
            if (write_hi) hi_q <= mdu.MDU_a;
            if (write_lo) lo_q <= mdu.MDU_a;
        end
    end

    assign mdu.E_MDU_out   = (mdu.CU_MDU_op == mdMfhi) ? hi_q :
                             (mdu.CU_MDU_op == mdMflo) ? lo_q : 32'd0;
    assign mdu.E_MDU_busy  = (state_q == RUN);
    assign mdu.E_MDU_stall = (state_q == RUN) | (mdu.CU_MDU_start & is_muldiv(mdu.CU_MDU_op));

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: vector table of mul/div ops with a HI/LO scoreboard,
// plus hand sequences for mthi/mfhi, req cancellation, div-by-zero and reset.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    e_mdu_ctrl_if mif ();

    e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;
    vec_t vecs[8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, want);
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, want);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic start, input logic rq);
        mif.CU_MDU_op    = op;
        mif.MDU_a        = a;
        mif.MDU_b        = b;
        mif.CU_MDU_start = start;
        mif.req          = rq;
    endtask

    task automatic idle_in();
        drive(mdNone, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Issue a mul/div at the current negedge; returns at the negedge after acceptance.
    task automatic start_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        drive(op, a, b, 1'b1, 1'b0);
        #1;
        check32({tag, "_stall_start"}, {31'd0, mif.E_MDU_stall}, 32'd1);
        e.hi  = ehi;
        e.lo  = elo;
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        idle_in();
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (mif.E_MDU_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_int("scoreboard_empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        drive(mdMfhi, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        check32({e.tag, "_hi"}, mif.E_MDU_out, e.hi);
        @(negedge clk);
        drive(mdMflo, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        check32({e.tag, "_lo"}, mif.E_MDU_out, e.lo);
        @(negedge clk);
        idle_in();
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        drive(op, val, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;

        vecs[0] = '{mdMult,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1] = '{mdMultu, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{mdDiv,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{mdDivu,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10};
        vecs[4] = '{mdDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5] = '{mdMult,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[6] = '{mdDiv,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[7] = '{mdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};

        // Reset state
        reset = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        check32("rst_busy", {31'd0, mif.E_MDU_busy}, 32'd0);
        check32("rst_stall", {31'd0, mif.E_MDU_stall}, 32'd0);
        drive(mdMfhi, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 check32("rst_hi", mif.E_MDU_out, 32'd0);
        drive(mdMflo, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 check32("rst_lo", mif.E_MDU_out, 32'd0);
        idle_in();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 8; i++) begin
            start_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            wait_done(0, n);
            check_int($sformatf("vec%0d_busy_cycles", i), n, vecs[i].cycles);
            read_check();
        end

        // mthi then immediate mfhi; mtlo then immediate mflo
        drive(mdMthi, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive(mdMfhi, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 check32("mthi_mfhi", mif.E_MDU_out, 32'h0000_1234);
        @(negedge clk);
        drive(mdMtlo, 32'h0000_5678, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive(mdMflo, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 check32("mtlo_mflo", mif.E_MDU_out, 32'h0000_5678);
        @(negedge clk);
        idle_in();

        // Op codes above mdMtlo behave as mdNone
        drive(4'd9, 32'h1, 32'h1, 1'b1, 1'b0);
        #1 check32("op9_stall", {31'd0, mif.E_MDU_stall}, 32'd0);
        check32("op9_out", mif.E_MDU_out, 32'd0);
        @(negedge clk);
        check32("op9_busy", {31'd0, mif.E_MDU_busy}, 32'd0);
        idle_in();

        // mult start with req: suppressed, HI/LO untouched
        move_to(mdMthi, 32'h0000_00AA);
        move_to(mdMtlo, 32'h0000_00BB);
        drive(mdMult, 32'hFFFF_FFFF, 32'h2, 1'b1, 1'b1);
        @(negedge clk);
        idle_in();
        check32("req_busy", {31'd0, mif.E_MDU_busy}, 32'd0);
        e.hi = 32'hAA; e.lo = 32'hBB; e.tag = "req_start";
        sb_q.push_back(e);
        read_check();

        // req in the middle of a div: the div still completes
        start_md("req_mid", mdDiv, 32'd100, 32'd7, 32'd2, 32'd14);
        n = 0;
        repeat (3) begin n++; @(negedge clk); end
        drive(mdMult, 32'h3, 32'h3, 1'b1, 1'b1);
        repeat (2) begin n++; @(negedge clk); end
        idle_in();
        wait_done(n, n);
        check_int("req_mid_busy_cycles", n, 10);
        read_check();

        // Start while busy is ignored
        start_md("busy_ign", mdMult, 32'd2, 32'd3, 32'd0, 32'd6);
        drive(mdDiv, 32'd100, 32'd7, 1'b1, 1'b0);
        @(negedge clk);
        idle_in();
        wait_done(1, n);
        check_int("busy_ign_busy_cycles", n, 5);
        read_check();

        // Divide by zero with HI/LO preloaded
        move_to(mdMthi, 32'h0000_00AA);
        move_to(mdMtlo, 32'h0000_00BB);
`ifdef MDU_DIVZERO_HOLD_EN
        start_md("div0", mdDiv, 32'd5, 32'd0, 32'hAA, 32'hBB);
`else
        start_md("div0", mdDiv, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
`endif
        wait_done(0, n);
        check_int("div0_busy_cycles", n, 10);
        read_check();
`ifdef MDU_DIVZERO_HOLD_EN
        start_md("divu0", mdDivu, 32'd9, 32'd0, 32'hAA, 32'hBB);
`else
        start_md("divu0", mdDivu, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
`endif
        wait_done(0, n);
        check_int("divu0_busy_cycles", n, 10);
        read_check();

        // Reset at busy cycle 3 of a mult
        move_to(mdMthi, 32'h0000_00AA);
        move_to(mdMtlo, 32'h0000_00BB);
        drive(mdMult, 32'd3, 32'd4, 1'b1, 1'b0);
        @(negedge clk);
        idle_in();
        repeat (2) @(negedge clk);
        check32("rstmid_busy_before", {31'd0, mif.E_MDU_busy}, 32'd1);
        reset = 1'b0;
        #1 check32("rstmid_busy", {31'd0, mif.E_MDU_busy}, 32'd0);
        drive(mdMfhi, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 check32("rstmid_hi", mif.E_MDU_out, 32'd0);
        drive(mdMflo, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 check32("rstmid_lo", mif.E_MDU_out, 32'd0);
        idle_in();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        e.hi = 32'd0; e.lo = 32'd0; e.tag = "rstmid_nowrite";
        sb_q.push_back(e);
        read_check();
        start_md("post_rst", mdMultu, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_done(0, n);
        check_int("post_rst_busy_cycles", n, 5);
        read_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
